// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline interlock for a 5-stage core with a multicycle
// multiply/divide unit.
//   clk, rst            - clock, synchronous active-high reset
//   id_rs/id_rt         - ID-stage source register numbers
//   id_uses_rs/rt       - ID instruction actually reads that operand
//   id_is_mfhilo        - ID instruction is MFHI/MFLO
//   ex_is_load/ex_we/ex_wr_rn - EX-stage load / write-back info
//   md_start/md_is_div  - multiply/divide issue from EX
//   pause, id_bubble    - freeze front end / squash ID->EX (Mealy)
//   md_busy             - HI/LO result still pending
//   hz_state            - 0 RUN, 1 LD_STALL, 2 MD_WAIT
//   stall_cnt           - saturating count of paused cycles
//
// state    | meaning
// RUN      | no hazard outstanding
// LD_STALL | one-cycle load-use bubble; load result now forwards from MEM
// MD_WAIT  | MFHI/MFLO waiting for the multiply/divide counter to drain
module hazard_ctl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_mfhilo,
  input  logic        ex_is_load,
  input  logic        ex_we,
  input  logic [4:0]  ex_wr_rn,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        pause,
  output logic        id_bubble,
  output logic        md_busy,
  output logic [1:0]  hz_state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MD_WAIT  = 2'd2
  } hz_state_e;

  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES);

  hz_state_e   state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        md_busy_q, md_busy_d;

  logic ld_haz, md_haz, stall;

  always_comb begin
    ld_haz = ex_is_load && ex_we && (ex_wr_rn != 5'd0) &&
             ((id_uses_rs && (id_rs == ex_wr_rn)) ||
              (id_uses_rt && (id_rt == ex_wr_rn)));
    md_haz = id_is_mfhilo && (md_start || (md_cnt_q != 6'd0));
    // The load in EX has already been waited on once while in LD_STALL.
    stall  = !rst && (md_haz || (ld_haz && (state_q != LD_STALL)));

    state_d = RUN;
    if (md_haz)
      state_d = MD_WAIT;
    else if ((state_q == RUN) && ld_haz)
      state_d = LD_STALL;

    md_cnt_d = md_cnt_q;
    if (md_start)
      md_cnt_d = md_is_div ? DIV_LD : MUL_LD;
    else if (md_cnt_q != 6'd0)
      md_cnt_d = md_cnt_q - 6'd1;

    md_busy_d = (md_cnt_d != 6'd0);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= 6'd0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_busy_q   <= md_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pause     = stall;
  assign id_bubble = stall;
  assign md_busy   = md_busy_q && !rst;
  assign hz_state  = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
